prg_loader: RTL
===============

# prg_loader

Streams a PRG image from the MiST `ioctl` download channel into system RAM over a request/acknowledge DMA port. It sits between `mist_io` and the PET hardware bus arbiter, and replaces the inline two-byte-header capture logic. The first two bytes of the image are taken as a little-endian load address. Payload bytes are buffered in a parametrised FIFO and issued as DMA writes whenever the bus grants them. On completion the block reports the end address and can optionally patch BASIC's program-end pointers.

## Interface
Parameters:
- `AW`, 16: RAM address width. Load address, DMA address and end address are all `AW` bits.
- `DEPTH_LOG2`, 3: FIFO depth is 2^`DEPTH_LOG2` bytes.
- `PTR_BASE`, 16'h002A: address of the first BASIC pointer to patch.
- `PTR_COUNT`, 3: number of consecutive 16-bit pointers to patch.

Ports:
- `clk`, in, 1: system clock.
- `reset`, in, 1: asynchronous, active-high reset.
- `sel`, in, 1: this download index is selected (index match, decoded externally).
- `ioctl_download`, in, 1: download in progress.
- `ioctl_wr`, in, 1: byte strobe, one cycle wide.
- `ioctl_addr`, in, 25: byte offset within the file.
- `ioctl_dout`, in, 8: file byte.
- `dma_req`, out, 1: write request (level).
- `dma_addr`, out, `AW`: write address.
- `dma_dout`, out, 8: write data.
- `dma_ack`, in, 1: grant. A transfer occurs in the cycle where `dma_req & dma_ack`.
- `busy`, out, 1: not IDLE.
- `done`, out, 1: one-cycle completion pulse.
- `error`, out, 1: sticky error flag. Cleared at the start of the next download.
- `end_addr`, out, `AW`: address one past the last payload byte.

## Operation
- Active download = `sel & ioctl_download`. Byte accepted = active download `& ioctl_wr`.
- States: IDLE, HDR, DATA, DRAIN, PATCH, FINISH.
- IDLE -> HDR on the rising edge of active download. On entry: clear `error`, flush the FIFO.
- HDR:
  - Byte at offset 0 -> `load_addr[7:0]`.
  - Byte at offset 1 -> `load_addr[AW-1:8]`. Upper bits are truncated when `AW` < 16 and zero-extended when `AW` > 16. Then set `wr_addr = load_addr` and go to DATA.
- DATA: each accepted byte with offset >= 2 is pushed to the FIFO.
  - A push while the FIFO is full is dropped and sets `error`.
- The FIFO head drives `dma_dout`, and `wr_addr` drives `dma_addr`. `dma_req` = FIFO not empty and not wrapped.
  - On each transfer: pop the FIFO and set `wr_addr += 1` modulo 2^`AW`.
  - Increment from all-ones to zero sets `wrapped` and `error`. Remaining bytes are popped without asserting `dma_req`.
- Falling edge of active download:
  - From HDR (fewer than 2 bytes received): set `error` and go to FINISH. No DMA is issued.
  - From DATA: go to DRAIN.
- DRAIN: on FIFO empty, latch `end_addr = wr_addr`, then go to PATCH if `PRG_PTR_PATCH_EN` is defined, else FINISH.
- PATCH: issue 2·`PTR_COUNT` transfers, in order, through the same handshake.
  - Pointer i is written as `end_addr[7:0]` to `PTR_BASE+2i` and `end_addr[15:8]` to `PTR_BASE+2i+1`.
  - PATCH is skipped if `error` is set.
- FINISH: assert `done` for one cycle, then go to IDLE.
- Simultaneous push and pop on the same cycle is legal; the FIFO count is unchanged.
- A new active-download rising edge in any non-IDLE state aborts immediately:
  - FIFO is flushed, `dma_req` drops the next cycle, the state restarts in HDR, and `error` is cleared.
  - No `done` pulse is generated for the aborted load.
- The consumer must tolerate request withdrawal. An unacked request carries no obligation.

## Timing
- Reset values: `dma_req`=0, `dma_addr`=0, `dma_dout`=0, `busy`=0, `done`=0, `error`=0, `end_addr`=0, state IDLE, FIFO empty.
- `dma_req` is registered. It is first asserted the cycle after the first payload push.
- `dma_addr` and `dma_dout` are stable while `dma_req` is high without `dma_ack`.
- With `dma_ack` tied high, sustained throughput is one byte per cycle.
- `done` is asserted no earlier than the cycle after the last transfer.
- `busy` rises the cycle after the download rising edge and falls with `done`.

## Configuration
- `PRG_PTR_PATCH_EN` defined: the PATCH state exists and issues 2·`PTR_COUNT` pointer writes after the payload.
- `PRG_PTR_PATCH_EN` undefined: PATCH logic is absent and DRAIN goes directly to FINISH. `end_addr` is still reported.

## Test plan
- File 01 04 AA BB CC, `dma_ack`=1 -> transfers at 0x0401/AA, 0x0402/BB, 0x0403/CC; `end_addr`=0x0404; one `done` pulse; `error`=0.
- Same file with patch enabled, defaults -> after payload, writes 0x002A=04, 0x002B=04, 0x002C=04, 0x002D=04, 0x002E=04, 0x002F=04, in that order.
- `dma_ack` held low, 10 payload bytes, depth 8 -> bytes 9 and 10 dropped; `error`=1; first 8 written once ack is released; pointers not patched.
- Header FE FF plus 4 bytes -> writes at 0xFFFE and 0xFFFF only; `error`=1; `end_addr`=0x0000.
- Download of a single byte -> no `dma_req`; `error`=1; `done` pulses. Restart mid-DATA -> FIFO flushed, no `done` for the first load, second load completes normally.

Source files
------------

// File: rtl/prg_loader.sv
// prg_loader: streams a PRG image from the ioctl download channel into RAM over a req/ack DMA port.
// Define PRG_PTR_PATCH_EN to patch BASIC's program-end pointers once the payload has landed.
module prg_loader #(
  parameter int          AW         = 16,
  parameter int          DEPTH_LOG2 = 3,
  parameter logic [15:0] PTR_BASE   = 16'h002A,
  parameter int          PTR_COUNT  = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          sel,
  input  logic          ioctl_download,
  input  logic          ioctl_wr,
  input  logic [24:0]   ioctl_addr,
  input  logic [7:0]    ioctl_dout,
  output logic          dma_req,
  output logic [AW-1:0] dma_addr,
  output logic [7:0]    dma_dout,
  input  logic          dma_ack,
  output logic          busy,
  output logic          done,
  output logic          error,
  output logic [AW-1:0] end_addr
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam int PW = $clog2(2 * PTR_COUNT);
  localparam logic [PW-1:0] PATCH_LAST = PW'(2 * PTR_COUNT - 1);

`ifdef PRG_PTR_PATCH_EN
  localparam bit PATCH_EN = 1'b1;
`else
  localparam bit PATCH_EN = 1'b0;
`endif

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_HDR    = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_DRAIN  = 3'd3;
  localparam logic [2:0] S_PATCH  = 3'd4;
  localparam logic [2:0] S_FINISH = 3'd5;

  logic [2:0]            state_reg, state_next;
  logic                  active_reg;
  logic [7:0]            load_lo_reg, load_lo_next;
  logic [AW-1:0]         wr_addr_reg, wr_addr_next;
  logic [DEPTH_LOG2-1:0] wr_ptr_reg, wr_ptr_next;
  logic [DEPTH_LOG2-1:0] rd_ptr_reg, rd_ptr_next;
  logic [DEPTH_LOG2:0]   count_reg, count_next;
  logic                  wrapped_reg, wrapped_next;
  logic                  error_reg, error_next;
  logic [AW-1:0]         end_addr_reg, end_addr_next;
  logic [PW-1:0]         patch_idx_reg, patch_idx_next;
  logic                  dma_req_reg, dma_req_next;
  logic [AW-1:0]         dma_addr_reg, dma_addr_next;
  logic [7:0]            dma_dout_reg, dma_dout_next;

  logic [7:0]            mem [DEPTH];

  logic active, rise, fall, accept, xfer;
  logic push, push_ok, pop, fifo_xfer;
  logic [7:0]  head_next;
  logic [15:0] end16;

  assign active = sel & ioctl_download;
  assign rise   = active & ~active_reg;
  assign fall   = ~active & active_reg;
  assign accept = active & ioctl_wr;
  assign xfer   = dma_req_reg & dma_ack;

  always_comb begin
    state_next     = state_reg;
    load_lo_next   = load_lo_reg;
    wr_addr_next   = wr_addr_reg;
    wr_ptr_next    = wr_ptr_reg;
    rd_ptr_next    = rd_ptr_reg;
    count_next     = count_reg;
    wrapped_next   = wrapped_reg;
    error_next     = error_reg;
    end_addr_next  = end_addr_reg;
    patch_idx_next = patch_idx_reg;

    // FIFO side: a wrapped load keeps popping silently until empty
    fifo_xfer = xfer && (state_reg != S_PATCH);
    pop       = (count_reg != '0) && (fifo_xfer || wrapped_reg);
    push      = (state_reg == S_DATA) && accept && (ioctl_addr >= 25'd2) && !rise;
    push_ok   = push && (count_reg != FULL);
    if (push && !push_ok) error_next = 1'b1;
    if (push_ok) wr_ptr_next = wr_ptr_reg + 1'b1;
    if (pop)     rd_ptr_next = rd_ptr_reg + 1'b1;
    case ({push_ok, pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
    if (fifo_xfer && (count_reg != '0)) begin
      wr_addr_next = wr_addr_reg + 1'b1;
      if (wr_addr_reg == '1) begin
        wrapped_next = 1'b1;
        error_next   = 1'b1;
      end
    end

    case (state_reg)
      S_HDR: begin
        if (fall) begin
          error_next = 1'b1;
          state_next = S_FINISH;
        end else if (accept) begin
          if (ioctl_addr == 25'd0) begin
            load_lo_next = ioctl_dout;
          end else if (ioctl_addr == 25'd1) begin
            wr_addr_next = AW'({ioctl_dout, load_lo_reg});
            state_next   = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (fall) state_next = S_DRAIN;
      end
      S_DRAIN: begin
        if (count_reg == '0) begin
          end_addr_next  = wr_addr_reg;
          patch_idx_next = '0;
          state_next     = (PATCH_EN && !error_reg) ? S_PATCH : S_FINISH;
        end
      end
      S_PATCH: begin
        if (xfer) begin
          if (patch_idx_reg == PATCH_LAST) state_next = S_FINISH;
          else patch_idx_next = patch_idx_reg + 1'b1;
        end
      end
      S_FINISH: state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase

    // A new download edge restarts from scratch in any state
    if (rise) begin
      state_next   = S_HDR;
      wr_ptr_next  = '0;
      rd_ptr_next  = '0;
      count_next   = '0;
      wrapped_next = 1'b0;
      error_next   = 1'b0;
      if (accept && (ioctl_addr == 25'd0)) load_lo_next = ioctl_dout;
    end

    // Head of the FIFO after this edge; bypass when the pushed byte becomes the head
    if (push_ok && (rd_ptr_next == wr_ptr_reg)) head_next = ioctl_dout;
    else head_next = mem[rd_ptr_next];

    end16         = 16'(end_addr_next);
    dma_req_next  = 1'b0;
    dma_addr_next = wr_addr_next;
    dma_dout_next = head_next;
    if ((state_next == S_DATA) || (state_next == S_DRAIN)) begin
      dma_req_next = (count_next != '0) && !wrapped_next;
    end else if (PATCH_EN && (state_next == S_PATCH)) begin
      dma_req_next  = 1'b1;
      dma_addr_next = AW'(PTR_BASE) + AW'(patch_idx_next);
      dma_dout_next = patch_idx_next[0] ? end16[15:8] : end16[7:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= S_IDLE;
      active_reg    <= 1'b0;
      load_lo_reg   <= '0;
      wr_addr_reg   <= '0;
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      wrapped_reg   <= 1'b0;
      error_reg     <= 1'b0;
      end_addr_reg  <= '0;
      patch_idx_reg <= '0;
      dma_req_reg   <= 1'b0;
      dma_addr_reg  <= '0;
      dma_dout_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      active_reg    <= active;
      load_lo_reg   <= load_lo_next;
      wr_addr_reg   <= wr_addr_next;
      wr_ptr_reg    <= wr_ptr_next;
      rd_ptr_reg    <= rd_ptr_next;
      count_reg     <= count_next;
      wrapped_reg   <= wrapped_next;
      error_reg     <= error_next;
      end_addr_reg  <= end_addr_next;
      patch_idx_reg <= patch_idx_next;
      dma_req_reg   <= dma_req_next;
      dma_addr_reg  <= dma_addr_next;
      dma_dout_reg  <= dma_dout_next;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_reg] <= ioctl_dout;
  end

  assign dma_req  = dma_req_reg;
  assign dma_addr = dma_addr_reg;
  assign dma_dout = dma_dout_reg;
  assign busy     = (state_reg != S_IDLE);
  assign done     = (state_reg == S_FINISH);
  assign error    = error_reg;
  assign end_addr = end_addr_reg;

endmodule
